vga_box_writer: RTL and testbench

VGA_BOX_WRITER -- requirements
Module: vga_box_writer

---
 rtl/vga_box_writer_pkg.sv | 36 +++
 rtl/vga_box_writer_addr.sv | 21 ++
 rtl/vga_box_writer.sv | 146 ++++++++++++++
 tb/tb_vga_box_writer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_box_writer_pkg.sv
// Shared constants, width helpers and FSM state type for the VGA box writer.
// Resolution-dependent sizes are derived from a low-resolution flag (160x120 when set).
package vga_box_writer_pkg;

   localparam int XMAX_320X240 = 320;
   localparam int YMAX_320X240 = 240;
   localparam int XMAX_160X120 = 160;
   localparam int YMAX_160X120 = 120;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRAW   = 2'd1,
      FINISH = 2'd2
   } state_t;

   function automatic int xw_of(input bit low_res);
      return low_res ? 8 : 9;
   endfunction

   function automatic int yw_of(input bit low_res);
      return low_res ? 7 : 8;
   endfunction

   function automatic int aw_of(input bit low_res);
      return low_res ? 15 : 17;
   endfunction

   function automatic int xmax_of(input bit low_res);
      return low_res ? XMAX_160X120 : XMAX_320X240;
   endfunction

   function automatic int ymax_of(input bit low_res);
      return low_res ? YMAX_160X120 : YMAX_320X240;
   endfunction

endpackage

// File: rtl/vga_box_writer_addr.sv
// Combinational dot-to-address map, y*XMAX+x truncated to AW bits.
// XMAX is 320 = 256+64 or 160 = 128+32, so two shifted copies of y replace a multiplier.
module vga_box_writer_addr
   import vga_box_writer_pkg::*;
#(
   parameter RESOLUTION = "320x240",
   localparam bit LOW_RES = (RESOLUTION == "160x120"),
   localparam int XW = xw_of(LOW_RES),
   localparam int YW = yw_of(LOW_RES),
   localparam int AW = aw_of(LOW_RES),
   localparam int SH_HI = LOW_RES ? 7 : 8,
   localparam int SH_LO = LOW_RES ? 5 : 6
) (
   input  logic [XW:0]   x,
   input  logic [YW:0]   y,
   output logic [AW-1:0] address
);

   assign address = (AW'(y) << SH_HI) + (AW'(y) << SH_LO) + AW'(x);

endmodule

// File: rtl/vga_box_writer.sv
// Fills a rectangle of video memory one dot per cycle, row-major, from a latched command.
// Define VGA_BOX_WRITER_CLIP_EN to clamp each box to the screen when it is accepted.
module vga_box_writer
   import vga_box_writer_pkg::*;
#(
   parameter int BITS_PER_COLOUR_CHANNEL = 1,
   parameter RESOLUTION = "320x240",
   localparam bit LOW_RES = (RESOLUTION == "160x120"),
   localparam int XW = xw_of(LOW_RES),
   localparam int YW = yw_of(LOW_RES),
   localparam int AW = aw_of(LOW_RES),
   localparam int C  = 3 * BITS_PER_COLOUR_CHANNEL
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [XW-1:0] cmd_x,
   input  logic [YW-1:0] cmd_y,
   input  logic [XW-1:0] cmd_w,
   input  logic [YW-1:0] cmd_h,
   input  logic [C-1:0]  cmd_colour,
   output logic          wr_en,
   output logic [AW-1:0] wr_address,
   output logic [C-1:0]  wr_colour,
   output logic          busy,
   output logic          done,
   output logic [1:0]    fsm_state
);

   // Handshake: a command transfers on a rising edge with cmd_valid && cmd_ready;
   // cmd_ready is high only in IDLE, so a command offered while busy simply waits.
   state_t state, state_n;

   logic [XW-1:0] x0;
   logic [XW:0]   x_end, cur_x, cur_x_n, x_inc;
   logic [YW:0]   y_end, cur_y, cur_y_n, y_inc;
   logic [XW:0]   w_eff;
   logic [YW:0]   h_eff;
   logic          accept, empty, row_end, last, wr_en_n;
   logic [AW-1:0] gen_address;

   assign accept    = (state == IDLE) && cmd_valid;
   assign cmd_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign done      = (state == FINISH);
   assign fsm_state = state;

`ifdef VGA_BOX_WRITER_CLIP_EN
   localparam logic [XW:0] XMAX_C = (XW+1)'(xmax_of(LOW_RES));
   localparam logic [YW:0] YMAX_C = (YW+1)'(ymax_of(LOW_RES));

   always_comb begin
      w_eff = {1'b0, cmd_w};
      h_eff = {1'b0, cmd_h};
      if (({1'b0, cmd_x} >= XMAX_C) || ({1'b0, cmd_y} >= YMAX_C)) begin
         w_eff = '0;
         h_eff = '0;
      end else begin
         if ({1'b0, cmd_w} > (XMAX_C - {1'b0, cmd_x})) w_eff = XMAX_C - {1'b0, cmd_x};
         if ({1'b0, cmd_h} > (YMAX_C - {1'b0, cmd_y})) h_eff = YMAX_C - {1'b0, cmd_y};
      end
   end
`else
   assign w_eff = {1'b0, cmd_w};
   assign h_eff = {1'b0, cmd_h};
`endif

   assign empty   = (w_eff == '0) || (h_eff == '0);
   assign x_inc   = cur_x + 1'b1;
   assign y_inc   = cur_y + 1'b1;
   assign row_end = (x_inc == x_end);
   assign last    = row_end && (y_inc == y_end);

   // cur_x/cur_y hold the dot currently on the write port; *_n is the dot for the next edge.
   always_comb begin
      state_n = state;
      wr_en_n = 1'b0;
      cur_x_n = cur_x;
      cur_y_n = cur_y;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               if (empty) begin
                  state_n = FINISH;
               end else begin
                  state_n = DRAW;
                  wr_en_n = 1'b1;
                  cur_x_n = {1'b0, cmd_x};
                  cur_y_n = {1'b0, cmd_y};
               end
            end
         end
         DRAW: begin
            if (last) begin
               state_n = FINISH;
            end else begin
               wr_en_n = 1'b1;
               if (row_end) begin
                  cur_x_n = {1'b0, x0};
                  cur_y_n = y_inc;
               end else begin
                  cur_x_n = x_inc;
               end
            end
         end
         FINISH:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   vga_box_writer_addr #(
      .RESOLUTION(RESOLUTION)
   ) u_addr (
      .x       (cur_x_n),
      .y       (cur_y_n),
      .address (gen_address)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         wr_en      <= 1'b0;
         wr_address <= '0;
         wr_colour  <= '0;
         cur_x      <= '0;
         cur_y      <= '0;
         x0         <= '0;
         x_end      <= '0;
         y_end      <= '0;
      end else begin
         state      <= state_n;
         wr_en      <= wr_en_n;
         wr_address <= gen_address;
         cur_x      <= cur_x_n;
         cur_y      <= cur_y_n;
         if (accept) begin
            x0        <= cmd_x;
            x_end     <= {1'b0, cmd_x} + w_eff;
            y_end     <= {1'b0, cmd_y} + h_eff;
            wr_colour <= cmd_colour;
         end
      end
   end

endmodule

// File: tb/tb_vga_box_writer.sv
// Directed bench for vga_box_writer: a 320x240 instance plus a 160x120 instance.
// Expected addresses come from hand constants or a y*XMAX+x model held in exp_q.
module tb_vga_box_writer;

   logic clk;
   logic reset;

   logic        cmd_valid, cmd_ready;
   logic [8:0]  cmd_x, cmd_w;
   logic [7:0]  cmd_y, cmd_h;
   logic [2:0]  cmd_colour;
   logic        wr_en, busy, done;
   logic [16:0] wr_address;
   logic [2:0]  wr_colour;
   logic [1:0]  fsm_state;

   logic        lo_cmd_valid, lo_cmd_ready;
   logic [7:0]  lo_cmd_x, lo_cmd_w;
   logic [6:0]  lo_cmd_y, lo_cmd_h;
   logic [2:0]  lo_cmd_colour;
   logic        lo_wr_en, lo_busy, lo_done;
   logic [14:0] lo_wr_address;
   logic [2:0]  lo_wr_colour;
   logic [1:0]  lo_fsm_state;

   logic [16:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   vga_box_writer #(.BITS_PER_COLOUR_CHANNEL(1), .RESOLUTION("320x240")) dut (
      .clock(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_colour(cmd_colour),
      .wr_en(wr_en), .wr_address(wr_address), .wr_colour(wr_colour),
      .busy(busy), .done(done), .fsm_state(fsm_state)
   );

   vga_box_writer #(.BITS_PER_COLOUR_CHANNEL(1), .RESOLUTION("160x120")) dut_lo (
      .clock(clk), .reset(reset), .cmd_valid(lo_cmd_valid), .cmd_ready(lo_cmd_ready),
      .cmd_x(lo_cmd_x), .cmd_y(lo_cmd_y), .cmd_w(lo_cmd_w), .cmd_h(lo_cmd_h),
      .cmd_colour(lo_cmd_colour), .wr_en(lo_wr_en), .wr_address(lo_wr_address),
      .wr_colour(lo_wr_colour), .busy(lo_busy), .done(lo_done), .fsm_state(lo_fsm_state)
   );

   // clock/reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // model: row-major dots of a box, optional clamp, address truncated to AW
   task automatic push_box(input bit lo, input int x, input int y, input int w, input int h);
      int xmax, ymax, modulo;
      xmax   = lo ? 160 : 320;
      ymax   = lo ? 120 : 240;
      modulo = lo ? 32768 : 131072;
`ifdef VGA_BOX_WRITER_CLIP_EN
      if (x >= xmax || y >= ymax) begin
         w = 0;
         h = 0;
      end else begin
         if (w > xmax - x) w = xmax - x;
         if (h > ymax - y) h = ymax - y;
      end
`endif
      for (int yy = 0; yy < h; yy++)
         for (int xx = 0; xx < w; xx++)
            exp_q.push_back(17'(((y + yy) * xmax + (x + xx)) % modulo));
   endtask

   // driver: present a command at a negedge, return at the negedge after the accept edge
   task automatic send_cmd(input bit lo, input int x, input int y, input int w, input int h,
                           input int col);
      if (lo) begin
         lo_cmd_x = 8'(x); lo_cmd_y = 7'(y); lo_cmd_w = 8'(w); lo_cmd_h = 7'(h);
         lo_cmd_colour = 3'(col); lo_cmd_valid = 1'b1;
      end else begin
         cmd_x = 9'(x); cmd_y = 8'(y); cmd_w = 9'(w); cmd_h = 8'(h);
         cmd_colour = 3'(col); cmd_valid = 1'b1;
      end
      @(negedge clk);
      lo_cmd_valid = 1'b0;
      cmd_valid    = 1'b0;
   endtask

   // scoreboard: n consecutive writes must match the head of exp_q
   task automatic emit_writes(input string tag, input bit lo, input int col, input int n);
      logic [16:0] exp_a;
      for (int i = 0; i < n && exp_q.size() > 0; i++) begin
         exp_a = exp_q.pop_front();
         check({tag, "_wr_en"}, lo ? 32'(lo_wr_en) : 32'(wr_en), 1);
         check({tag, "_addr"}, lo ? 32'(lo_wr_address) : 32'(wr_address), 32'(exp_a));
         check({tag, "_colour"}, lo ? 32'(lo_wr_colour) : 32'(wr_colour), col);
         check({tag, "_busy"}, lo ? 32'(lo_busy) : 32'(busy), 1);
         @(negedge clk);
      end
   endtask

   task automatic expect_done(input string tag, input bit lo);
      check({tag, "_done_wr_en"}, lo ? 32'(lo_wr_en) : 32'(wr_en), 0);
      check({tag, "_done"}, lo ? 32'(lo_done) : 32'(done), 1);
      check({tag, "_done_busy"}, lo ? 32'(lo_busy) : 32'(busy), 1);
      check({tag, "_done_state"}, lo ? 32'(lo_fsm_state) : 32'(fsm_state), 2);
      @(negedge clk);
      check({tag, "_after_done"}, lo ? 32'(lo_done) : 32'(done), 0);
      check({tag, "_ready"}, lo ? 32'(lo_cmd_ready) : 32'(cmd_ready), 1);
      check({tag, "_idle_busy"}, lo ? 32'(lo_busy) : 32'(busy), 0);
   endtask

   initial begin
      reset = 1'b1;
      cmd_valid = 1'b0; cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_colour = '0;
      lo_cmd_valid = 1'b0; lo_cmd_x = '0; lo_cmd_y = '0; lo_cmd_w = '0; lo_cmd_h = '0;
      lo_cmd_colour = '0;
      repeat (3) @(negedge clk);

      check("rst_ready", 32'(cmd_ready), 1);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_wr_en", 32'(wr_en), 0);
      check("rst_addr", 32'(wr_address), 0);
      check("rst_colour", 32'(wr_colour), 0);
      check("rst_state", 32'(fsm_state), 0);
      reset = 1'b0;
      @(negedge clk);

      // 3x2 box at (10,20), hand-computed addresses
      exp_q = '{17'd6410, 17'd6411, 17'd6412, 17'd6730, 17'd6731, 17'd6732};
      send_cmd(0, 10, 20, 3, 2, 3'b101);
      check("a_state", 32'(fsm_state), 1);
      check("a_ready_low", 32'(cmd_ready), 0);
      emit_writes("a", 0, 3'b101, 6);
      expect_done("a", 0);

      // empty boxes: done one cycle after accept, no writes
      send_cmd(0, 7, 9, 0, 5, 3'b011);
      expect_done("w0", 0);
      send_cmd(0, 7, 9, 3, 0, 3'b011);
      expect_done("h0", 0);

      // second command held during a 4x4 box
      exp_q.delete();
      push_box(0, 100, 50, 4, 4);
      send_cmd(0, 100, 50, 4, 4, 3'b010);
      cmd_x = 9'd5; cmd_y = 8'd6; cmd_w = 9'd4; cmd_h = 8'd4; cmd_colour = 3'b111;
      cmd_valid = 1'b1;
      emit_writes("b1", 0, 3'b010, 16);
      check("b1_done", 32'(done), 1);
      check("b1_done_ready", 32'(cmd_ready), 0);
      check("b1_done_wr_en", 32'(wr_en), 0);
      @(negedge clk);
      check("gap_ready", 32'(cmd_ready), 1);
      check("gap_wr_en", 32'(wr_en), 0);
      check("gap_done", 32'(done), 0);
      @(negedge clk);
      cmd_valid = 1'b0;
      push_box(0, 5, 6, 4, 4);
      emit_writes("b2", 0, 3'b111, 16);
      expect_done("b2", 0);

      // reset after the 5th write aborts the box
      exp_q.delete();
      push_box(0, 20, 30, 4, 4);
      send_cmd(0, 20, 30, 4, 4, 3'b001);
      emit_writes("r", 0, 3'b001, 4);
      check("r_5th_wr_en", 32'(wr_en), 1);
      check("r_5th_addr", 32'(wr_address), 32'(exp_q[0]));
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      check("r_wr_en", 32'(wr_en), 0);
      check("r_ready", 32'(cmd_ready), 1);
      check("r_busy", 32'(busy), 0);
      for (int i = 0; i < 4; i++) begin
         check("r_no_done", 32'(done), 0);
         check("r_no_wr", 32'(wr_en), 0);
         @(negedge clk);
      end

      // bottom-right corner overhang
`ifdef VGA_BOX_WRITER_CLIP_EN
      exp_q = '{17'd76798, 17'd76799};
`else
      push_box(0, 318, 239, 4, 3);
`endif
      send_cmd(0, 318, 239, 4, 3, 3'b110);
      emit_writes("corner", 0, 3'b110, 12);
      expect_done("corner", 0);

      // start column at XMAX
      exp_q.delete();
      push_box(0, 320, 0, 1, 1);
      send_cmd(0, 320, 0, 1, 1, 3'b100);
      emit_writes("x320", 0, 3'b100, 1);
      expect_done("x320", 0);

      // largest x plus width: the end sum must not wrap
      exp_q.delete();
      push_box(0, 511, 0, 2, 1);
      send_cmd(0, 511, 0, 2, 1, 3'b011);
      emit_writes("xmaxsum", 0, 3'b011, 2);
      expect_done("xmaxsum", 0);

      // 160x120 instance
      exp_q = '{17'd19199};
      send_cmd(1, 159, 119, 1, 1, 3'b101);
      emit_writes("lo_corner", 1, 3'b101, 1);
      expect_done("lo_corner", 1);
      exp_q.delete();
      push_box(1, 158, 1, 2, 2);
      send_cmd(1, 158, 1, 2, 2, 3'b010);
      emit_writes("lo_box", 1, 3'b010, 4);
      expect_done("lo_box", 1);

      check("end_queue_empty", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
